// File: rtl/way_select_decoder_pkg.sv
// Shared cache definitions: way count, the encoder "no match" index,
// and the decoded-way result layout used by the decoder and its clients.
package way_select_decoder_pkg;

    // Default number of cache ways and the index width that covers them.
    localparam int WAYS  = 4;
    localparam int IDX_W = 4;

    // Index the lowest-set-bit encoder emits when no bit is set.
    localparam int NONE_IDX = WAYS;

    // Decoded way result at the default way count.
    typedef struct packed {
        logic [WAYS-1:0] onehot;
        logic            none;
        logic            err;
    } way_dec_t;

endpackage

// File: rtl/way_select_decoder_index_to_onehot.sv
// Combinational way index to one-hot decoder.
// Ports: idx (index in), onehot (select vector), none (idx==OUT_SIZE), err (idx>OUT_SIZE).
module index_to_onehot
    import way_select_decoder_pkg::*;
#(
    parameter int IN_SIZE  = IDX_W,
    parameter int OUT_SIZE = WAYS
) (
    input  logic [IN_SIZE-1:0]  idx,
    output logic [OUT_SIZE-1:0] onehot,
    output logic                none,
    output logic                err
);

    localparam logic [IN_SIZE-1:0] NONE_I = IN_SIZE'(OUT_SIZE);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < OUT_SIZE; i++) begin
            onehot[i] = (idx == IN_SIZE'(i));
        end
        none = (idx == NONE_I);
        err  = (idx > NONE_I);
    end

endmodule

// File: rtl/way_select_decoder.sv
// Registered index-to-one-hot decoder with a main + skid output buffer.
// Ports: clk, rst_n, in_valid/in_ready/in (index side),
//        out_valid/out_ready/out/out_none/out_err (decoded result side).
module way_select_decoder
    import way_select_decoder_pkg::*;
#(
    parameter int IN_SIZE  = IDX_W,
    parameter int OUT_SIZE = WAYS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_SIZE-1:0]  in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_SIZE-1:0] out,
    output logic                out_none,
    output logic                out_err
);

    typedef struct packed {
        logic [OUT_SIZE-1:0] onehot;
        logic                none;
        logic                err;
    } dec_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    occ_e state_q, state_d;
    dec_t main_q, main_d;
    dec_t skid_q, skid_d;
    dec_t dec;

    logic acc;
    logic pop;

    index_to_onehot #(
        .IN_SIZE  (IN_SIZE),
        .OUT_SIZE (OUT_SIZE)
    ) u_dec (
        .idx    (in),
        .onehot (dec.onehot),
        .none   (dec.none),
        .err    (dec.err)
    );

    // Ready and valid come straight from occupancy state.
    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);

    assign acc = in_valid && in_ready;
    assign pop = out_valid && out_ready;

    // Gate the outputs so stale main contents never show while empty.
    assign out      = out_valid ? main_q.onehot : '0;
    assign out_none = out_valid && main_q.none;
    assign out_err  = out_valid && main_q.err;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (acc) begin
                    main_d  = dec;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (acc && pop) begin
                    main_d = dec;
                end else if (acc) begin
                    skid_d  = dec;
                    state_d = TWO;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_way_select_decoder.sv
// Self-checking bench for way_select_decoder.
// Scoreboard of expected results, checked when the DUT pops a result.
module tb_way_select_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_idx = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out;
    logic       out_none;
    logic       out_err;

    int checks = 0;
    int passed = 0;
    logic [5:0] sb[$];
    logic [5:0] exp_v;

    always #5 clk = ~clk;

    way_select_decoder #(
        .IN_SIZE  (4),
        .OUT_SIZE (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_none  (out_none),
        .out_err   (out_err)
    );

    function automatic logic [5:0] model(input int idx);
        case (idx)
            0: return 6'b0001_00;
            1: return 6'b0010_00;
            2: return 6'b0100_00;
            3: return 6'b1000_00;
            4: return 6'b0000_10;
            default: return 6'b0000_01;
        endcase
    endfunction

    function automatic int enc(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return 4;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready, out, out_none, out_err} !== 8'b0100_0000)
            $display("FAIL reset: got v=%b r=%b o=%b n=%b e=%b want v=0 r=1 o=0000 n=0 e=0",
                     out_valid, in_ready, out, out_none, out_err);
        else passed++;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        in_idx = 4'd2;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) $display("FAIL single_ready: got %b want 1", in_ready);
        else passed++;
        sb.push_back(model(2));
        tick();
        in_valid = 1'b0;
        in_idx = 'x;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) $display("FAIL single_latency: out_valid got %b want 1", out_valid);
        else passed++;
        exp_v = sb.pop_front();
        checks++;
        if ({out, out_none, out_err} !== exp_v)
            $display("FAIL single_data: got %b want %b", {out, out_none, out_err}, exp_v);
        else passed++;
        tick();
        @(negedge clk);
        checks++;
        if ({out_valid, out} !== 5'b0_0000)
            $display("FAIL single_idle: got v=%b o=%b want v=0 o=0000", out_valid, out);
        else passed++;
        tick();
    endtask

    task automatic test_sweep();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_idx = 4'(i);
            in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) $display("FAIL sweep_ready[%0d]: got %b want 1", i, in_ready);
            else passed++;
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1) $display("FAIL sweep_rate[%0d]: out_valid got %b want 1", i, out_valid);
                else passed++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) $display("FAIL sweep_extra: got %b want nothing", {out, out_none, out_err});
                else begin
                    exp_v = sb.pop_front();
                    if ({out, out_none, out_err} !== exp_v)
                        $display("FAIL sweep_data: got %b want %b", {out, out_none, out_err}, exp_v);
                    else passed++;
                end
            end
            sb.push_back(model(i));
            tick();
        end
        in_valid = 1'b0;
        in_idx = 'x;
        for (int c = 0; c < 6 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                exp_v = sb.pop_front();
                checks++;
                if ({out, out_none, out_err} !== exp_v)
                    $display("FAIL sweep_drain: got %b want %b", {out, out_none, out_err}, exp_v);
                else passed++;
            end
            tick();
        end
        checks++;
        if (sb.size() != 0) $display("FAIL sweep_timeout: pending got %0d want 0", sb.size());
        else passed++;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_idx = 4'd1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) $display("FAIL bp_ready0: got %b want 1", in_ready);
        else passed++;
        sb.push_back(model(1));
        tick();
        in_idx = 4'd3;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) $display("FAIL bp_ready1: got %b want 1", in_ready);
        else passed++;
        sb.push_back(model(3));
        tick();
        in_idx = 'x;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out} !== 6'b0_1_0010)
            $display("FAIL bp_full: got r=%b v=%b o=%b want r=0 v=1 o=0010", in_ready, out_valid, out);
        else passed++;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({out, out_none, out_err} !== 6'b0010_00)
            $display("FAIL bp_hold: got %b want 001000", {out, out_none, out_err});
        else passed++;
        tick();
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (!out_valid || sb.size() == 0)
                $display("FAIL bp_pop%0d: out_valid got %b want 1", k, out_valid);
            else begin
                exp_v = sb.pop_front();
                if ({out, out_none, out_err} !== exp_v)
                    $display("FAIL bp_pop%0d: got %b want %b", k, {out, out_none, out_err}, exp_v);
                else passed++;
            end
            checks++;
            if (in_ready !== (k == 1))
                $display("FAIL bp_inready%0d: got %b want %b", k, in_ready, k == 1);
            else passed++;
            tick();
        end
        @(negedge clk);
        checks++;
        if ({out_valid, out} !== 5'b0_0000)
            $display("FAIL bp_empty: got v=%b o=%b want v=0 o=0000", out_valid, out);
        else passed++;
        sb.delete();
        tick();
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_idx = 4'(i);
            in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) $display("FAIL stream_ready[%0d]: got %b want 1", i, in_ready);
            else passed++;
            if (out_valid) begin
                checks++;
                if (sb.size() == 0) $display("FAIL stream_extra: got %b want nothing", out);
                else begin
                    exp_v = sb.pop_front();
                    if ({out, out_none, out_err} !== exp_v)
                        $display("FAIL stream_order: got %b want %b", {out, out_none, out_err}, exp_v);
                    else passed++;
                end
            end
            sb.push_back(model(i));
            tick();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 6 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (out_valid) begin
                exp_v = sb.pop_front();
                checks++;
                if ({out, out_none, out_err} !== exp_v)
                    $display("FAIL stream_drain: got %b want %b", {out, out_none, out_err}, exp_v);
                else passed++;
            end
            tick();
        end
        checks++;
        if (sb.size() != 0) $display("FAIL stream_timeout: pending got %0d want 0", sb.size());
        else passed++;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_idx = 4'd0;
        tick();
        in_idx = 4'd5;
        tick();
        in_valid = 1'b0;
        in_idx = 'x;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid} !== 2'b01)
            $display("FAIL arst_fill: got r=%b v=%b want r=0 v=1", in_ready, out_valid);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, out, out_none, out_err} !== 8'b0100_0000)
            $display("FAIL arst_now: got v=%b r=%b o=%b n=%b e=%b want v=0 r=1 o=0000 n=0 e=0",
                     out_valid, in_ready, out, out_none, out_err);
        else passed++;
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, out} !== 5'b0_0000)
                $display("FAIL arst_stale%0d: got v=%b o=%b want v=0 o=0000", c, out_valid, out);
            else passed++;
        end
        tick();
    endtask

    task automatic test_roundtrip();
        logic [3:0] vecs [3];
        logic [5:0] want [3];
        vecs[0] = 4'b0110; want[0] = 6'b0010_00;
        vecs[1] = 4'b0000; want[1] = 6'b0000_10;
        vecs[2] = 4'b1000; want[2] = 6'b1000_00;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_idx = 4'(enc(vecs[i]));
            in_valid = 1'b1;
            @(negedge clk);
            if (out_valid && sb.size() > 0) begin
                exp_v = sb.pop_front();
                checks++;
                if ({out, out_none, out_err} !== exp_v)
                    $display("FAIL rt_data: got %b want %b", {out, out_none, out_err}, exp_v);
                else passed++;
            end
            if (in_ready) sb.push_back(want[i]);
            tick();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 6 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (out_valid) begin
                exp_v = sb.pop_front();
                checks++;
                if ({out, out_none, out_err} !== exp_v)
                    $display("FAIL rt_drain: got %b want %b", {out, out_none, out_err}, exp_v);
                else passed++;
            end
            tick();
        end
        checks++;
        if (sb.size() != 0) $display("FAIL rt_timeout: pending got %0d want 0", sb.size());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_sweep();
        test_backpressure();
        test_stream();
        test_async_reset();
        test_roundtrip();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/way_select_decoder.md
Name: way_select_decoder

Overview:
- Registered index-to-one-hot decoder with valid/ready handshakes on both sides.
- It is the inverse of the cache's lowest-set-bit encoder. It turns a way or victim index back into a one-hot way write-enable / select vector for the cache data and tag arrays.
- A two-entry (main + skid) output buffer gives full throughput under back-pressure.
- The encoder's "no bit set" result (index == OUT_SIZE) is decoded as an explicit "none" response, not an error.

Parameters:
- IN_SIZE, 4, width of the index input (must satisfy 2^IN_SIZE > OUT_SIZE).
- OUT_SIZE, 4, number of one-hot output lines (cache ways).

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  index presented this cycle.
- in_ready  output  1  decoder can accept an index this cycle.
- in  input  IN_SIZE  way index, unsigned.
- out_valid  output  1  out/out_none/out_err hold a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- out  output  OUT_SIZE  one-hot decoded vector (all-zero for none/err).
- out_none  output  1  index equalled OUT_SIZE (encoder "no match").
- out_err  output  1  index greater than OUT_SIZE (illegal).

Behaviour:
- Reset (rst_n low, async): main and skid entries emptied; out_valid=0, out=0, out_none=0, out_err=0; in_ready=1. Reset asserted mid-operation discards all buffered results; no partial output is emitted after release.
- Decode rule:
  - in < OUT_SIZE: out bit[in]=1, all other bits 0, none=0, err=0.
  - in == OUT_SIZE: out=0, none=1, err=0.
  - in > OUT_SIZE: out=0, none=0, err=1.
  - Exactly one of {one bit of out, none, err} is set in every valid result.
- Input transfer: occurs when in_valid && in_ready at a rising edge. Output transfer: occurs when out_valid && out_ready.
- Latency: an index accepted at edge T appears on the outputs after edge T, i.e. out_valid is high in cycle T+1 if the main entry was empty or drained at T. No combinational path from in to out.
- in_ready = !skid_full. It is registered state, so no combinational path from out_ready to in_ready.
- Buffer states (occupancy):
  - EMPTY.
    - Accept: main <= decoded, go to ONE.
  - ONE.
    - Accept and pop: main <= decoded, stay ONE.
    - Accept without pop: skid <= decoded, go to TWO.
    - Pop without accept: go to EMPTY.
    - Neither: hold.
  - TWO (in_ready=0).
    - Pop: main <= skid, go to ONE.
    - No pop: hold.
- While out_valid=1 and out_ready=0, out/out_none/out_err are stable.
- Results leave in acceptance order; none are lost or duplicated.
- in is ignored when in_valid=0 or in_ready=0; X on in in those cycles must not propagate.
- out is all-zero whenever out_valid=0.

Decomposition:
- Shared cache package holds:
  - the decode-result struct {onehot[OUT_SIZE], none, err};
  - the NONE index constant (= OUT_SIZE), shared with the encoder;
  - the default way count.
- One combinational sub-module, index_to_onehot, implements the decode rule.
  - Reused by the replacement logic.
  - Instantiated once, before the buffer, so both entries store already-decoded results.

Test Plan:
- Reset then single index: in=2 with in_valid one cycle, out_ready=1 → next cycle out_valid=1, out=4'b0100, none=0, err=0; following cycle out_valid=0, out=0.
- Sweep with out_ready=1: in=0,1,2,3,4,5 back-to-back → out=0001,0010,0100,1000,0000(none=1),0000(err=1). One result per cycle, in_ready stays 1.
- Back-pressure: out_ready=0, push in=1 then in=3 → in_ready drops to 0 after the second accept; out holds 0010. Raise out_ready → 0010 then 1000 on consecutive cycles; in_ready returns to 1.
- Simultaneous accept and pop in ONE state: stream in=0..3 with out_ready=1 → skid never used, in_ready constant 1, order preserved.
- Async reset mid-operation: fill both entries, pulse rst_n low between clock edges → out_valid=0 and in_ready=1 immediately. After release no stale result appears.
- Encoder round-trip: encoder output for in vectors 4'b0110, 4'b0000, 4'b1000 → decoder yields 0010, none=1, 1000 respectively.
